multi_cycle_controller: RTL
===========================

# multi_cycle_controller

Control unit for the multi-cycle RV32I core. Consumes instruction fields and the ALU `Zero` flag from the datapath and drives every datapath enable and mux select, one instruction step per clock. A Moore main FSM sequences fetch/decode/execute/writeback; combinational ALU and immediate decoders complete the control word.

## Interface
Parameters: none.
- `CLK`  in  1  rising-edge clock
- `RESET`  in  1  asynchronous, active-low reset
- `OP`  in  7  `Instr[6:0]`
- `funct3`  in  3  `Instr[14:12]`
- `funct7`  in  1  `Instr[30]`
- `Zero`  in  1  ALU zero flag
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result
- `MemWrite`  out  1  memory write enable
- `IRWrite`  out  1  captures the instruction and OldPC
- `RegWrite`  out  1  register-file write enable
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = A
- `ALUSrcB`  out  2  00 = WriteData, 01 = ImmExt, 10 = 4
- `ImmSrc`  out  2  00 = I, 01 = S, 10 = B, 11 = J
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `State`  out  4  current FSM state, for debug and verification

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10. Codes 11–15 go to FETCH on the next cycle with all enables 0.
- Transitions:
  - FETCH→DECODE.
  - DECODE: lw(0000011) or sw(0100011)→MEMADR; R(0110011)→EXECUTER; I(0010011)→EXECUTEI; branch(1100011)→BRANCH; jal(1101111)→JAL; any other opcode→FETCH with no writes.
  - MEMADR: lw→MEMREAD, otherwise MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER, EXECUTEI and JAL→ALUWB→FETCH.
  - BRANCH→FETCH.
- Outputs per state (unlisted outputs are 0; select fields are 00):
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1, ALUOp=00.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - BRANCH: ALUSrcA=10, ALUOp=01, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- `PCWrite` = PCUpdate | (Branch & take), where take = `Zero` for funct3 000.
- ALU decode:
  - ALUOp 00→add; ALUOp 01→sub.
  - ALUOp 10 by funct3: 000→sub if `OP[5]` & `funct7`, else add; 010→slt; 110→or; 111→and; any other→add.
- `ImmSrc` is decoded from `OP` in every state: sw→01, branch→10, jal→11, otherwise 00.

## Timing
- Only the state register is sequential; all outputs are combinational from state and inputs, with no added latency.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, branch 3, jal 4, illegal opcode 2.
- Reset:
  - `RESET` low asynchronously forces FETCH.
  - While `RESET` is low, PCWrite, IRWrite, RegWrite and MemWrite are forced 0; selects take their FETCH values.
  - Reset mid-instruction abandons the instruction with no further writes.
- First FETCH write occurs on the first rising edge after `RESET` deasserts.
- `Zero` is sampled only in BRANCH, combinationally in the same cycle.

## Configuration
- `CTRL_BNE_EN` defined: branch funct3 001 (bne) takes when `Zero`=0; funct3 000 unchanged.
- `CTRL_BNE_EN` undefined: only funct3 000 can take; funct3 001 and all other branch funct3 values run BRANCH with `PCWrite`=0.

## Structure
- Shared package `riscv_ctrl_pkg`:
  - state encoding
  - opcode constants
  - ALUOp and ALUControl codes
  - ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings
- Sub-module `alu_decoder`: combinational; inputs ALUOp, funct3, `OP[5]`, funct7; output `ALUControl`.
- FSM, ImmSrc decode and PCWrite logic live in the top module.

## Test plan
- Reset low mid-MEMREAD → `State`=0 immediately, all enables 0; release → next edge IRWrite=1, PCWrite=1.
- lw (OP=0000011) → `State` 0,1,2,3,4,0; MEMWB: RegWrite=1, ResultSrc=01; MEMREAD: AdrSrc=1.
- sub (OP=0110011, funct3=000, funct7=1) → EXECUTER with ALUControl=001, then ALUWB RegWrite=1; addi with funct7=1 → ALUControl=000.
- beq (OP=1100011) with Zero=1 → BRANCH PCWrite=1; with Zero=0 → PCWrite=0; back to FETCH after 3 cycles.
- bne (funct3=001), Zero=0 → PCWrite=1 with `CTRL_BNE_EN`, 0 without.
- Illegal OP=1111111 → FETCH→DECODE→FETCH, no RegWrite/MemWrite asserted.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multi-cycle RV32I controller.
// Holds the state, opcode, ALU and datapath-select codes.
package riscv_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp plus instruction function bits to an ALU operation.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7,
    output logic [2:0] alu_control
);
    logic [2:0] funct_ctrl;

    always_comb begin
        case (funct3)
            3'b000:  funct_ctrl = (op5 && funct7) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctrl = ALU_SLT;
            3'b110:  funct_ctrl = ALU_OR;
            3'b111:  funct_ctrl = ALU_AND;
            default: funct_ctrl = ALU_ADD;
        endcase
        alu_control = (alu_op == ALUOP_FUNCT) ? funct_ctrl :
                      (alu_op == ALUOP_SUB)   ? ALU_SUB    : ALU_ADD;
    end
endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: Moore control FSM for the multi-cycle RV32I core.
// Define CTRL_BNE_EN to let BRANCH also take bne (funct3 001).
module multi_cycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] OP,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State
);
    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update, branch, take, ir_write, reg_write, mem_write;

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) state_q <= S_FETCH;
        else        state_q <= state_d;

    always_comb begin
        state_d   = S_FETCH;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_WD;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                state_d   = S_DECODE;
                ir_write  = 1'b1;
                pc_update = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (OP)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                state_d = S_MEMWB;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                state_d = S_ALUWB;
                ALUSrcA = SRCA_A;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                state_d = S_ALUWB;
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_A;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                state_d   = S_ALUWB;
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

`ifdef CTRL_BNE_EN
    assign take = (funct3 == 3'b000) ? Zero : (funct3 == 3'b001) ? !Zero : 1'b0;
`else
    assign take = (funct3 == 3'b000) && Zero;
`endif

    // Enables are gated by RESET so nothing writes while reset is held.
    assign PCWrite  = RESET && (pc_update || (branch && take));
    assign IRWrite  = RESET && ir_write;
    assign RegWrite = RESET && reg_write;
    assign MemWrite = RESET && mem_write;
    assign State    = state_q;
    assign ImmSrc   = (OP == OP_SW)  ? IMM_S :
                      (OP == OP_BR)  ? IMM_B :
                      (OP == OP_JAL) ? IMM_J : IMM_I;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (OP[5]),
        .funct7      (funct7),
        .alu_control (ALUControl)
    );
endmodule
